lfsr_range_gen: RTL

Parametrised Fibonacci-LFSR random source with runtime seeding, a zero-state lockup guard, and a handshaked bounded-draw engine. It returns uniformly distributed values in [0, limit) by masked rejection sampling. It sits between the game controller and the mole/target selection logic, replacing the fixed 8-bit free-running generator. The raw LFSR state also stays visible for other consumers.

---
 rtl/lfsr_range_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lfsr_range_gen.sv
// Fibonacci LFSR random source with runtime seeding, a zero-state guard, and a
// handshaked engine that draws uniform values in [0, limit) by masked rejection.
module lfsr_range_gen #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0]   INIT_SEED = 16'hACE1,
  parameter int                 OUT_W     = 4,
  parameter int                 MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_limit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic             out_fallback,
  output logic [WIDTH-1:0] random
);

  localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W:0]   lim_r;
  logic [OUT_W-1:0] mask_r;
  logic [TRY_W-1:0] tries;

  logic [OUT_W:0]   lim_in;
  logic [OUT_W-1:0] cand;
  logic [OUT_W:0]   cand_ext;
  logic [OUT_W:0]   fb_diff;
  logic             hit;
  logic             last_try;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // A limit of zero selects the full 2^OUT_W range, hence the extra bit.
  function automatic logic [OUT_W:0] range_of(input logic [OUT_W-1:0] l);
    return (l == '0) ? {1'b1, {OUT_W{1'b0}}} : {1'b0, l};
  endfunction

  // Smallest all-ones mask covering lim-1; lim is never zero here.
  function automatic logic [OUT_W-1:0] mask_for(input logic [OUT_W:0] lim);
    logic [OUT_W:0] m;
    m = lim - (OUT_W + 1)'(1);
    for (int i = 1; i <= OUT_W; i++) begin
      m = m | (m >> i);
    end
    return m[OUT_W-1:0];
  endfunction

  assign lim_in   = range_of(req_limit);
  assign cand     = random[OUT_W-1:0] & mask_r;
  assign cand_ext = {1'b0, cand};
  assign hit      = (cand_ext < lim_r);
  assign fb_diff  = cand_ext - lim_r;
  assign last_try = (tries == LAST_TRY);

  // LFSR: reset, then seed load, then zero-state recovery, then stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      random <= INIT_SEED;
    end else if (seed_load) begin
      random <= (seed_in == '0) ? INIT_SEED : seed_in;
    end else if (random == '0) begin
      random <= INIT_SEED;
    end else if (en || (state == DRAW)) begin
      random <= lfsr_step(random);
    end
  end

  // Draw bookkeeping; always re-initialised when a request is accepted.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      lim_r  <= lim_in;
      mask_r <= mask_for(lim_in);
      tries  <= '0;
    end else if ((state == DRAW) && !hit && !last_try) begin
      tries  <= tries + TRY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_fallback <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= DRAW;
            req_ready <= 1'b0;
          end
        end
        DRAW: begin
          if (hit) begin
            out_value    <= cand;
            out_fallback <= 1'b0;
            out_valid    <= 1'b1;
            state        <= RESP;
          end else if (last_try) begin
            // mask < 2*lim, so a rejected candidate minus lim is in range.
            out_value    <= fb_diff[OUT_W-1:0];
            out_fallback <= 1'b1;
            out_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
